// File: rtl/uart_tx_mmio_if.sv
// Core data-bus port bundle for the memory-mapped UART transmitter.
// The master drives address/wdata/we; the slave returns registered rdata/rdata_hit.
interface uart_tx_mmio_if;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic        rdata_hit;

   modport master (output address, output wdata, output we, input rdata, input rdata_hit);
   modport slave  (input address, input wdata, input we, output rdata, output rdata_hit);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD_DIV window, TX queue, serializer.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter logic [15:0] DEFAULT_DIV = 16'd867,
   parameter int          FIFO_DEPTH  = 8
) (
   input  logic          clk,
   input  logic          resetn,
   uart_tx_mmio_if.slave bus,
   output logic          txd,
   output logic          irq
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state, state_n;
   logic [15:0] div;
   logic [15:0] bcnt, bcnt_n;
   logic [2:0]  bitcnt, bitcnt_n;
   logic [7:0]  shift, shift_n;
   logic [7:0]  head;
   logic        txd_n;
   logic        pop;
   logic        full, empty;
   logic        overflow;
   logic [3:0]  count;
   logic        hit, wr, push_req, push_ok;
   logic [1:0]  idx;
   logic [31:0] status;
   logic        unused_bits;

   assign hit      = (bus.address[31:4] == BASE_ADDR[31:4]);
   assign idx      = bus.address[3:2];
   assign wr       = bus.we && hit;
   assign push_req = wr && (idx == 2'd0);
   // Full is the pre-edge value, so a push coinciding with a pop while full is dropped.
   assign push_ok  = push_req && !full;

   assign unused_bits = ^{bus.address[1:0], bus.wdata[31:16]};

`ifdef UART_TX_FIFO_EN
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [3:0]    cnt;

   assign full  = (cnt == 4'(FIFO_DEPTH));
   assign empty = (cnt == 4'd0);
   assign count = cnt;
   assign head  = mem[rptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= 4'd0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         if (push_ok && !pop)      cnt <= cnt + 4'd1;
         else if (pop && !push_ok) cnt <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= bus.wdata[7:0];
   end
`else
   logic       occ;
   logic [7:0] hold;
   logic       unused_cfg;

   assign full       = occ;
   assign empty      = !occ;
   assign count      = {3'd0, occ};
   assign head       = hold;
   assign unused_cfg = (FIFO_DEPTH == 0);

   always_ff @(posedge clk) begin
      if (!resetn)      occ <= 1'b0;
      else if (push_ok) occ <= 1'b1;
      else if (pop)     occ <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push_ok) hold <= bus.wdata[7:0];
   end
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         div      <= DEFAULT_DIV;
         overflow <= 1'b0;
      end else begin
         if (wr && idx == 2'd2) div <= bus.wdata[15:0];
         if (push_req && full)                          overflow <= 1'b1;
         else if (wr && idx == 2'd1 && bus.wdata[3])    overflow <= 1'b0;
      end
   end

   assign status = {20'd0, count, 4'd0, overflow, empty, full, (state != IDLE)};

   // Registered read path gives the same one-cycle latency as the data RAM.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus.rdata     <= 32'd0;
         bus.rdata_hit <= 1'b0;
      end else begin
         bus.rdata_hit <= hit;
         if (!hit) begin
            bus.rdata <= 32'd0;
         end else begin
            case (idx)
               2'd1:    bus.rdata <= status;
               2'd2:    bus.rdata <= {16'd0, div};
               default: bus.rdata <= 32'd0;
            endcase
         end
      end
   end

   always_comb begin
      state_n  = state;
      bcnt_n   = bcnt;
      bitcnt_n = bitcnt;
      shift_n  = shift;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               bcnt_n  = div;
               state_n = START;
            end
         end
         START: begin
            if (bcnt == 16'd0) begin
               bcnt_n   = div;
               bitcnt_n = 3'd0;
               state_n  = DATA;
            end else begin
               bcnt_n = bcnt - 16'd1;
            end
         end
         DATA: begin
            if (bcnt == 16'd0) begin
               shift_n = {1'b0, shift[7:1]};
               bcnt_n  = div;
               if (bitcnt == 3'd7) state_n = STOP;
               else                bitcnt_n = bitcnt + 3'd1;
            end else begin
               bcnt_n = bcnt - 16'd1;
            end
         end
         STOP: begin
            if (bcnt == 16'd0) begin
               // Chain straight into the next start bit when more data is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = head;
                  bcnt_n  = div;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               bcnt_n = bcnt - 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = shift_n[0];
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state  <= IDLE;
         bcnt   <= 16'd0;
         bitcnt <= 3'd0;
         txd    <= 1'b1;
         irq    <= 1'b1;
      end else begin
         state  <= state_n;
         bcnt   <= bcnt_n;
         bitcnt <= bitcnt_n;
         txd    <= txd_n;
         irq    <= (state == IDLE) && (count == 4'd0);
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_n;
   end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped 8N1 UART transmitter on the core's data bus, downstream of the core. It decodes `address`/`we`/`wdata` against its own register window and queues written bytes in a TX FIFO. A serializer shifts bytes out on `txd`. Reads return status and divisor with the same one-cycle synchronous-read latency as RAM, so the system read mux can select `rdata` whenever `rdata_hit` is set.

## Interface
- `BASE_ADDR`, 32'h0000_1000: register window base; the window is `BASE_ADDR[31:4]`, 16 bytes.
- `DEFAULT_DIV`, 16'd867: reset value of BAUD_DIV; each bit lasts BAUD_DIV+1 clk cycles.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, range 2..8; used only with `UART_TX_FIFO_EN`.
- `clk`  in  1  clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `address`  in  32  core bus byte address.
- `wdata`  in  32  core bus write data (core `data_out`).
- `we`  in  1  write enable; a write occurs at the posedge where `we`=1 and hit.
- `rdata`  out  32  registered read data.
- `rdata_hit`  out  1  registered: the previous cycle's address hit the window.
- `txd`  out  1  serial output; idle high.
- `irq`  out  1  level: FIFO empty and serializer idle.

## Operation
- Hit is `address[31:4] == BASE_ADDR[31:4]`. Register index is `address[3:2]`; `address[1:0]` is ignored and all accesses are full word.
- Offset 0x0, TXDATA, write-only: a write pushes `wdata[7:0]`. Reads return 0.
- Offset 0x4, STATUS: bit0 busy (state≠IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[11:8] count, all other bits 0.
  - Writing with `wdata[3]`=1 clears overflow. Other bits are read-only.
- Offset 0x8, BAUD_DIV: bits[15:0] R/W; upper bits read 0.
- Offset 0xC: reads 0; writes are ignored.
- The core performs sub-word stores as read-modify-write. A byte store to TXDATA therefore reads 0 and then writes a merged word, and pushes exactly one byte.
- A push when full is dropped and sets overflow. Full is evaluated before a same-cycle pop, so a push coincident with a pop while full is still dropped.
- Serializer FSM, with a bit counter `bitcnt` 0..7 and a baud counter `bcnt`:
  - IDLE: `txd`=1. If FIFO non-empty: pop into the shift register, load `bcnt`=BAUD_DIV, go to START.
  - START: `txd`=0. When `bcnt`==0: reload `bcnt`, set `bitcnt`=0, go to DATA. Otherwise decrement `bcnt`.
  - DATA: `txd`=shift[0], LSB first. When `bcnt`==0: shift right and reload `bcnt`. Go to STOP once `bitcnt`==7, else increment `bitcnt`.
  - STOP: `txd`=1. When `bcnt`==0: if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- BAUD_DIV written mid-frame takes effect at the next `bcnt` reload, i.e. at the next bit boundary.
- BAUD_DIV=0 gives one clk per bit.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is 4 bits.

## Timing
- Reset values: `txd`=1, `rdata`=0, `rdata_hit`=0, `irq`=1, state IDLE, FIFO empty, overflow 0, BAUD_DIV=DEFAULT_DIV.
- Reset asserted mid-frame aborts the frame: `txd`=1 after the reset edge and FIFO contents are discarded.
- Read latency: `rdata` and `rdata_hit` are valid in the cycle after the address is presented, matching RAM timing.
  - A non-hit cycle yields `rdata`=0 and `rdata_hit`=0 on the next cycle.
- Register writes take effect at the write posedge. STATUS read in the following cycle reflects them.
- Write latency: TXDATA written at edge N while IDLE and empty → count=1 after N → pop at edge N+1 → `txd` falls after N+1.
- Frame length is 10×(BAUD_DIV+1) cycles. Back-to-back frames have no gap.
- `irq` is registered from state and count and updates one cycle after they change.

## Configuration
- `UART_TX_FIFO_EN` defined: FIFO of FIFO_DEPTH entries.
- Not defined: a single holding register, i.e. depth 1.
  - full = holding register occupied.
  - count is 0 or 1.
  - FIFO_DEPTH is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then read STATUS → `rdata`=0x0000_0004 with `rdata_hit`=1 one cycle later; `txd`=1; `irq`=1.
- BAUD_DIV=3, write TXDATA=0xA5 → `txd` shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1. Each bit lasts 4 cycles, the frame is 40 cycles, and `irq` returns to 1 afterwards.
- With FIFO enabled and BAUD_DIV=0, write 0x01, 0x02, 0x03 consecutively → three 10-cycle frames with no idle gap, and count reads 2 then decreasing.
- With FIFO enabled and BAUD_DIV large, push 10 bytes → 9th byte accepted (one byte already popped), 10th dropped. STATUS reads full=1, overflow=1, count=8. Writing STATUS=0x8 clears overflow.
- Mid-frame BAUD_DIV change from 3 to 1 → the current bit keeps 4 cycles and subsequent bits last 2 cycles. Reset asserted mid-frame → `txd`=1 and STATUS empty after the edge.
- Accesses to address 0x0000_2000 → no push, `rdata_hit`=0, `rdata`=0.
